// File: rtl/onehot_encoder_hs.sv
// One-hot/priority request encoder: MSB set -> code 0, LSB set -> code N-1.
// Each new request word yields one result on a valid/ready handshake; stalled events are counted.
module onehot_encoder_hs #(
  parameter int N   = 4,
  parameter int DCW = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   in,
  input  logic           ready,
  output logic [CW-1:0]  out,
  output logic           valid,
  output logic           multi,
  output logic [DCW-1:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   prev_q, prev_d;
  logic [CW-1:0]  out_q, out_d;
  logic           multi_q, multi_d;
  logic [DCW-1:0] drop_q, drop_d;

  logic [CW-1:0]  enc_code;
  logic [CW:0]    ones;
  logic           enc_multi;
  logic           event_w;

  // Ascending scan so the highest set bit overwrites lower ones.
  always_comb begin
    enc_code = '0;
    ones     = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) enc_code = CW'(N - 1 - i);
      ones = ones + {{CW{1'b0}}, in[i]};
    end
    enc_multi = (ones > (CW+1)'(1));
  end

  assign event_w = en && (in != '0) && (in != prev_q);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    multi_d = multi_q;
    drop_d  = drop_q;
    prev_d  = en ? in : '0;
    unique case (state_q)
      IDLE: begin
        if (event_w) begin
          out_d   = enc_code;
          multi_d = enc_multi;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (event_w) begin
            out_d   = enc_code;
            multi_d = enc_multi;
          end else begin
            state_d = IDLE;
          end
        end else if (event_w && (drop_q != '1)) begin
          drop_d = drop_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      out_q   <= '0;
      multi_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      out_q   <= out_d;
      multi_q <= multi_d;
      drop_q  <= drop_d;
    end
  end

  assign out      = out_q;
  assign valid    = (state_q == HOLD);
  assign multi    = multi_q;
  assign drop_cnt = drop_q;

endmodule
